// File: rtl/fp32_to_int32_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp32_to_int32_pipe
// Desc     : 3-stage float32 -> int32 converter with power-of-two pre-scale,
//            round-half-to-even and int32 saturation. Optional macro
//            F2I_RELU_EN clamps every negative result to zero.
// Revision : 1.0 - initial release
// ============================================================================
module fp32_to_int32_pipe #(
  parameter int SCALE_EXP = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_data,
  output logic [CNT_W-1:0] sat_cnt
);

  localparam logic [2:0] c_cls_zero  = 3'd0;  // zero / denormal
  localparam logic [2:0] c_cls_nan   = 3'd1;
  localparam logic [2:0] c_cls_sat   = 3'd2;  // inf or out of int32 range
  localparam logic [2:0] c_cls_min   = 3'd3;  // exactly -2^31
  localparam logic [2:0] c_cls_big   = 3'd4;  // 23 <= E <= 30, left shift
  localparam logic [2:0] c_cls_small = 3'd5;  // -1 <= E <= 22, right shift
  localparam logic [2:0] c_cls_tiny  = 3'd6;  // E <= -2, always rounds to 0

  localparam logic signed [10:0] c_scale = 11'(SCALE_EXP);

  logic              w_en;
  logic signed [10:0] w_s1_exp;
  logic [2:0]        w_s1_cls;
  logic [4:0]        w_s1_shamt;

  logic              r_s1_valid;
  logic              r_s1_sign;
  logic [2:0]        r_s1_cls;
  logic [23:0]       r_s1_sig;
  logic [4:0]        r_s1_shamt;

  logic [31:0]       w_s2_lwide;
  logic [55:0]       w_s2_rwide;
  logic [31:0]       w_s2_mag;
  logic              w_s2_guard;
  logic              w_s2_sticky;

  logic              r_s2_valid;
  logic              r_s2_sign;
  logic [2:0]        r_s2_cls;
  logic [31:0]       r_s2_mag;
  logic              r_s2_guard;
  logic              r_s2_sticky;

  logic              w_s3_rnd;
  logic [32:0]       w_s3_mag;
  logic [31:0]       w_s3_data;
  logic              w_s3_sat;

  logic              r_s3_valid;
  logic [31:0]       r_s3_data;
  logic [CNT_W-1:0]  r_sat_cnt;

  // Single global enable: the whole pipe freezes while the output is stalled.
  assign w_en    = !r_s3_valid || m_ready;
  assign s_ready = w_en;
  assign m_valid = r_s3_valid;
  assign m_data  = r_s3_data;
  assign sat_cnt = r_sat_cnt;

  always_comb begin
    w_s1_exp   = $signed({3'b000, s_data[30:23]}) - 11'sd127 + c_scale;
    w_s1_cls   = c_cls_tiny;
    w_s1_shamt = 5'd0;
    if (s_data[30:23] == 8'd0) begin
      w_s1_cls = c_cls_zero;
    end else if (s_data[30:23] == 8'hFF) begin
      w_s1_cls = (s_data[22:0] != 23'd0) ? c_cls_nan : c_cls_sat;
    end else if (w_s1_exp >= 11'sd31) begin
      w_s1_cls = (s_data[31] && (w_s1_exp == 11'sd31) && (s_data[22:0] == 23'd0))
                 ? c_cls_min : c_cls_sat;
    end else if (w_s1_exp >= 11'sd23) begin
      w_s1_cls   = c_cls_big;
      w_s1_shamt = 5'(w_s1_exp - 11'sd23);
    end else if (w_s1_exp >= -11'sd1) begin
      w_s1_cls   = c_cls_small;
      w_s1_shamt = 5'(11'sd23 - w_s1_exp);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_cls   <= c_cls_zero;
      r_s1_sig   <= 24'd0;
      r_s1_shamt <= 5'd0;
    end else if (w_en) begin
      r_s1_valid <= s_valid;
      r_s1_sign  <= s_data[31];
      r_s1_cls   <= w_s1_cls;
      r_s1_sig   <= {1'b1, s_data[22:0]};
      r_s1_shamt <= w_s1_shamt;
    end
  end

  // Right-shift path keeps 32 fraction bits: [31] is guard, [30:0] feed sticky.
  always_comb begin
    w_s2_lwide  = {8'd0, r_s1_sig} << r_s1_shamt[2:0];
    w_s2_rwide  = {r_s1_sig, 32'd0} >> r_s1_shamt;
    w_s2_mag    = 32'd0;
    w_s2_guard  = 1'b0;
    w_s2_sticky = 1'b0;
    if (r_s1_cls == c_cls_big) begin
      w_s2_mag = w_s2_lwide;
    end else if (r_s1_cls == c_cls_small) begin
      w_s2_mag    = {8'd0, w_s2_rwide[55:32]};
      w_s2_guard  = w_s2_rwide[31];
      w_s2_sticky = |w_s2_rwide[30:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid  <= 1'b0;
      r_s2_sign   <= 1'b0;
      r_s2_cls    <= c_cls_zero;
      r_s2_mag    <= 32'd0;
      r_s2_guard  <= 1'b0;
      r_s2_sticky <= 1'b0;
    end else if (w_en) begin
      r_s2_valid  <= r_s1_valid;
      r_s2_sign   <= r_s1_sign;
      r_s2_cls    <= r_s1_cls;
      r_s2_mag    <= w_s2_mag;
      r_s2_guard  <= w_s2_guard;
      r_s2_sticky <= w_s2_sticky;
    end
  end

  always_comb begin
    w_s3_rnd  = r_s2_guard && (r_s2_sticky || r_s2_mag[0]);
    w_s3_mag  = {1'b0, r_s2_mag} + {32'd0, w_s3_rnd};
    w_s3_data = 32'd0;
    w_s3_sat  = 1'b0;
    case (r_s2_cls)
      c_cls_nan: begin
        w_s3_sat = 1'b1;
      end
      c_cls_sat: begin
        w_s3_data = r_s2_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
        w_s3_sat  = 1'b1;
      end
      c_cls_min: begin
        w_s3_data = 32'h8000_0000;
      end
      c_cls_big, c_cls_small, c_cls_tiny: begin
        if (w_s3_mag[32] || w_s3_mag[31]) begin
          // Rounding carry into 2^31: legal only as the most negative int.
          w_s3_data = r_s2_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
          w_s3_sat  = !r_s2_sign;
        end else begin
          w_s3_data = r_s2_sign ? (~w_s3_mag[31:0] + 32'd1) : w_s3_mag[31:0];
        end
      end
      default: begin
        w_s3_data = 32'd0;
      end
    endcase
`ifdef F2I_RELU_EN
    if (r_s2_sign && (r_s2_cls != c_cls_nan)) begin
      w_s3_data = 32'd0;
      w_s3_sat  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s3_valid <= 1'b0;
      r_s3_data  <= 32'd0;
      r_sat_cnt  <= {CNT_W{1'b0}};
    end else if (w_en) begin
      r_s3_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_s3_data <= w_s3_data;
        if (w_s3_sat && (r_sat_cnt != {CNT_W{1'b1}})) begin
          r_sat_cnt <= r_sat_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp32_to_int32_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp32_to_int32_pipe
// Desc     : Randomised bench with a real-arithmetic reference model and a
//            per-cycle output monitor. Honours F2I_RELU_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp32_to_int32_pipe;

  localparam int CNT_W   = 4;
  localparam int SAT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [31:0]      s_data = 32'd0;
  logic             m_valid;
  logic             m_ready = 1'b1;
  logic [31:0]      m_data;
  logic [CNT_W-1:0] sat_cnt;

  logic             s4_valid = 1'b0;
  logic             s4_ready;
  logic [31:0]      s4_data = 32'd0;
  logic             m4_valid;
  logic             m4_ready = 1'b1;
  logic [31:0]      m4_data;
  logic [15:0]      sat4_cnt;

  always #5 clk = ~clk;

  fp32_to_int32_pipe #(.SCALE_EXP(0), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .sat_cnt(sat_cnt)
  );

  fp32_to_int32_pipe #(.SCALE_EXP(4), .CNT_W(16)) u_dut4 (
    .clk(clk), .rst(rst), .s_valid(s4_valid), .s_ready(s4_ready), .s_data(s4_data),
    .m_valid(m4_valid), .m_ready(m4_ready), .m_data(m4_data), .sat_cnt(sat4_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Exact value sig * 2^(e-150+scale) in double precision, then RNE and clamp.
  function automatic logic [32:0] ref_conv(input logic [31:0] x, input int scale);
    int     e;
    int     k;
    real    a;
    real    r;
    real    fr;
    longint li;
    logic   neg;
    neg = x[31];
    e   = int'(x[30:23]);
    if (e == 0) return 33'd0;
    if (e == 255) begin
      if (x[22:0] != 23'd0) return {1'b1, 32'd0};
`ifdef F2I_RELU_EN
      if (neg) return 33'd0;
`endif
      return neg ? {1'b1, 32'h8000_0000} : {1'b1, 32'h7FFF_FFFF};
    end
    a = real'(int'(x[22:0]) + 8388608);
    k = e - 150 + scale;
    while (k > 0) begin a = a * 2.0; k--; end
    while (k < 0) begin a = a / 2.0; k++; end
    r  = $floor(a);
    fr = a - r;
    if (fr > 0.5) begin
      r = r + 1.0;
    end else if (fr == 0.5) begin
      li = longint'(r);
      if (li[0]) r = r + 1.0;
    end
`ifdef F2I_RELU_EN
    if (neg) return 33'd0;
`endif
    if (!neg) begin
      if (r >= 2147483648.0) return {1'b1, 32'h7FFF_FFFF};
      li = longint'(r);
      return {1'b0, li[31:0]};
    end
    if (r > 2147483648.0) return {1'b1, 32'h8000_0000};
    li = -longint'(r);
    return {1'b0, li[31:0]};
  endfunction

  function automatic logic [31:0] int_to_fp(input int n);
    int          k;
    logic [31:0] m;
    k = 0;
    while ((n >> (k + 1)) != 0) k++;
    m = 32'(n) << (23 - k);
    return {1'b0, 8'(127 + k), m[22:0]};
  endfunction

  function automatic logic [31:0] gen_word();
    logic [7:0]  e;
    logic [22:0] f;
    e = 8'd0;
    f = 23'd0;
    case ($urandom_range(0, 3))
      0: begin e = 8'($urandom); f = 23'($urandom); end
      1: begin e = 8'($urandom_range(120, 160)); f = 23'($urandom); end
      2: begin e = 8'($urandom_range(125, 151)); f = 23'($urandom_range(0, 7)) << $urandom_range(0, 20); end
      default: begin
        e = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
        f = ($urandom_range(0, 1) != 0) ? 23'd0 : 23'($urandom);
      end
    endcase
    return {1'($urandom), e, f};
  endfunction

  task automatic check_model(input string name, input logic [31:0] x, input int scale,
                             input logic [31:0] exp_data, input logic exp_sat);
    logic [32:0] r;
    r = ref_conv(x, scale);
    check({name, "_data"}, r[31:0], exp_data);
    check({name, "_sat"}, 32'(r[32]), 32'(exp_sat));
  endtask

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    logic [32:0] exp;
    int          cyc;
    int          stalls;
  } item_t;

  item_t       q[$];
  item_t       it;
  int          cyc = 0;
  int          stall_cnt = 0;
  int          model_sat = 0;
  int          pops = 0;
  logic        prev_stall = 1'b0;
  logic        prev_rst = 1'b0;
  logic [31:0] prev_data = 32'd0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      model_sat  = 0;
      prev_stall = 1'b0;
      prev_rst   = 1'b1;
    end else begin
      if (prev_rst) begin
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", m_data, 32'd0);
        check("rst_sat_cnt", 32'(sat_cnt), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);
      end
      prev_rst = 1'b0;
      if (prev_stall) begin
        check("stall_valid", 32'(m_valid), 32'd1);
        check("stall_data", m_data, prev_data);
      end
      check("s_ready", 32'(s_ready), 32'(!m_valid || m_ready));
      if (m_valid && m_ready) begin
        pops++;
        if (q.size() == 0) begin
          check("unexpected_output", m_data, 32'hDEAD_BEEF);
        end else begin
          it = q.pop_front();
          if (it.exp[32] && model_sat < SAT_MAX) model_sat++;
          check("m_data", m_data, it.exp[31:0]);
          check("sat_cnt", 32'(sat_cnt), 32'(model_sat));
          if (it.stalls == stall_cnt) check("latency", 32'(cyc - it.cyc), 32'd3);
        end
      end
      if (m_valid && !m_ready) stall_cnt++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (s_valid && s_ready) begin
        it.exp    = ref_conv(s_data, 0);
        it.cyc    = cyc;
        it.stalls = stall_cnt;
        q.push_back(it);
      end
    end
  end

  // ---------------- downstream ready generator ----------------
  int rdy_mode = 0;
  int rdy_pat  = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: m_ready = 1'b1;
        1: begin m_ready = (rdy_pat == 2); rdy_pat = (rdy_pat + 1) % 3; end
        default: m_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- drivers ----------------
  task automatic send(input logic [31:0] x);
    int   n;
    logic ok;
    n       = 0;
    ok      = 1'b0;
    s_valid = 1'b1;
    s_data  = x;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = s_ready;
      n++;
      @(posedge clk);
      #1;
    end
    if (!ok) check("send_timeout", 32'(n), 32'd0);
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || m_valid) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 1000) check("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic send4(input string name, input logic [31:0] x, input logic [31:0] exp);
    s4_valid = 1'b1;
    s4_data  = x;
    @(posedge clk);
    #1;
    s4_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check({name, "_valid"}, 32'(m4_valid), 32'd1);
    check(name, m4_data, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  logic [31:0] bnd [16] = '{32'h4EFF_FFFF, 32'hCEFF_FFFF, 32'h3F80_0001, 32'h8000_0000,
                            32'h0000_0001, 32'hFFC0_0000, 32'hFF80_0000, 32'h3EFF_FFFF,
                            32'h3F00_0001, 32'h4060_0000, 32'h4090_0000, 32'hCF00_0000,
                            32'hCF00_0001, 32'h4F00_0000, 32'hBF00_0000, 32'hBF40_0000};

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Hand-computed values that pin the reference model.
    check_model("m_1p5", 32'h3FC0_0000, 0, 32'd2, 1'b0);
    check_model("m_2p5", 32'h4020_0000, 0, 32'd2, 1'b0);
    check_model("m_0p5", 32'h3F00_0000, 0, 32'd0, 1'b0);
    check_model("m_0p75", 32'h3F40_0000, 0, 32'd1, 1'b0);
    check_model("m_3p5", 32'h4060_0000, 0, 32'd4, 1'b0);
    check_model("m_4p5", 32'h4090_0000, 0, 32'd4, 1'b0);
    check_model("m_2p31", 32'h4F00_0000, 0, 32'h7FFF_FFFF, 1'b1);
    check_model("m_pinf", 32'h7F80_0000, 0, 32'h7FFF_FFFF, 1'b1);
    check_model("m_nan", 32'h7FC0_0000, 0, 32'd0, 1'b1);
    check_model("m_max", 32'h4EFF_FFFF, 0, 32'h7FFF_FF80, 1'b0);
    check_model("m_s4_1", 32'h3F80_0000, 4, 32'd16, 1'b0);
    check_model("m_s4_3_32", 32'h3DC0_0000, 4, 32'd2, 1'b0);
    check_model("m_int7", int_to_fp(7), 0, 32'd7, 1'b0);
    check_model("m_p3", 32'h4040_0000, 0, 32'd3, 1'b0);
`ifdef F2I_RELU_EN
    check_model("m_neg1p5", 32'hBFC0_0000, 0, 32'd0, 1'b0);
    check_model("m_min", 32'hCF00_0000, 0, 32'd0, 1'b0);
    check_model("m_n3", 32'hC040_0000, 0, 32'd0, 1'b0);
    check_model("m_ninf", 32'hFF80_0000, 0, 32'd0, 1'b0);
    check_model("m_novf", 32'hCF00_0001, 0, 32'd0, 1'b0);
`else
    check_model("m_neg1p5", 32'hBFC0_0000, 0, 32'hFFFF_FFFE, 1'b0);
    check_model("m_min", 32'hCF00_0000, 0, 32'h8000_0000, 1'b0);
    check_model("m_n3", 32'hC040_0000, 0, 32'hFFFF_FFFD, 1'b0);
    check_model("m_ninf", 32'hFF80_0000, 0, 32'h8000_0000, 1'b1);
    check_model("m_novf", 32'hCF00_0001, 0, 32'h8000_0000, 1'b1);
`endif

    // Rounding, back-to-back with m_ready high.
    rdy_mode = 0;
    send(32'h3FC0_0000);
    send(32'h4020_0000);
    send(32'hBFC0_0000);
    send(32'h3F00_0000);
    send(32'h3F40_0000);
    // Saturation and specials.
    send(32'h4F00_0000);
    send(32'hCF00_0000);
    send(32'h7F80_0000);
    send(32'h7FC0_0000);
    send(32'hC040_0000);
    send(32'hFF80_0000);
    send(32'h4040_0000);
    drain();
`ifdef F2I_RELU_EN
    check("sat_cnt_final", 32'(sat_cnt), 32'd3);
`else
    check("sat_cnt_final", 32'(sat_cnt), 32'd4);
`endif

    // Scale path on the second instance.
    send4("s4_one", 32'h3F80_0000, 32'd16);
    send4("s4_3_32", 32'h3DC0_0000, 32'd2);
    check("s4_sat_cnt", 32'(sat4_cnt), 32'd0);

    // Backpressure with m_ready 0/0/1.
    base     = pops;
    rdy_mode = 1;
    for (int n = 1; n <= 10; n++) send(int_to_fp(n));
    drain();
    check("bp_count", 32'(pops - base), 32'd10);

    // Reset with three words in flight.
    rdy_mode = 0;
    @(posedge clk);
    #1;
    send(32'h4F00_0000);
    send(32'h7F80_0000);
    send(32'h4F00_0000);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("rst_no_stale_sat", 32'(sat_cnt), 32'd0);

    // Boundary values then randomised traffic with random backpressure.
    rdy_mode = 2;
    for (int i = 0; i < 16; i++) send(bnd[i]);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(gen_word());
    end
    drain();
    check("queue_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
